// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one Memory port between several clients.
// Routes responses back by tag and holds the grant across Long1/Long2.
module memory_arbiter #(
   parameter int REQUESTERS = 4,
   parameter int ARRAY_BITS = 16,
   parameter int INDEX_BITS = 3,
   parameter int DATA_BITS  = 16
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic [REQUESTERS-1:0]            req_valid,
   output logic [REQUESTERS-1:0]            req_ready,
   input  logic [8*REQUESTERS-1:0]          req_action,
   input  logic [ARRAY_BITS*REQUESTERS-1:0] req_array,
   input  logic [INDEX_BITS*REQUESTERS-1:0] req_index,
   input  logic [DATA_BITS*REQUESTERS-1:0]  req_in,
   output logic [REQUESTERS-1:0]            resp_valid,
   output logic [DATA_BITS-1:0]             resp_data,
   output logic [7:0]                       mem_action,
   output logic [ARRAY_BITS-1:0]            mem_array,
   output logic [INDEX_BITS-1:0]            mem_index,
   output logic [DATA_BITS-1:0]             mem_in,
   input  logic [DATA_BITS-1:0]             mem_out,
   output logic                             lock_active
);

   localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   localparam logic [7:0] ACT_LONG1 = 8'd12;
   localparam logic [7:0] ACT_LONG2 = 8'd13;

   typedef struct packed {
      logic          vld;
      logic [IW-1:0] id;
      logic          rd;
   } tag_t;

   logic [IW-1:0]         ptr_q, ptr_d;
   logic                  lock_q, lock_d;
   logic [IW-1:0]         owner_q, owner_d;
   tag_t                  tag1_q, tag1_d;
   tag_t                  tag2_q, tag2_d;
   logic [7:0]            mem_action_q, mem_action_d;
   logic [ARRAY_BITS-1:0] mem_array_q, mem_array_d;
   logic [INDEX_BITS-1:0] mem_index_q, mem_index_d;
   logic [DATA_BITS-1:0]  mem_in_q, mem_in_d;
   logic [REQUESTERS-1:0] resp_valid_q, resp_valid_d;
   logic [DATA_BITS-1:0]  resp_data_q, resp_data_d;

   logic [REQUESTERS-1:0] grant;
   logic [IW-1:0]         gid;
   logic                  found;
   logic                  fire;
   int                    k;
   logic [7:0]            sel_act;
   logic                  legal;
   logic                  returns_data;

   always_comb begin
      grant = '0;
      gid   = '0;
      found = 1'b0;
      k     = 0;
      if (lock_q) begin
         if (req_valid[owner_q]) begin
            found = 1'b1;
            gid   = owner_q;
         end
      end else begin
         for (int j = 0; j < REQUESTERS; j++) begin
            k = (int'(ptr_q) + j) % REQUESTERS;
            if (!found && req_valid[k]) begin
               found = 1'b1;
               gid   = IW'(k);
            end
         end
      end
      if (found) grant[gid] = 1'b1;
   end

   assign req_ready = reset_n ? grant : '0;
   assign fire      = reset_n & found;

   always_comb begin
      sel_act      = req_action[int'(gid)*8 +: 8];
      legal        = (sel_act >= 8'd1) && (sel_act <= 8'd17);
      returns_data = sel_act inside {8'd2, 8'd3, 8'd4, 8'd7,
                                     8'd8, 8'd9, 8'd15};

      mem_action_d = '0;
      mem_array_d  = '0;
      mem_index_d  = '0;
      mem_in_d     = '0;
      tag1_d       = '0;
      ptr_d        = ptr_q;
      lock_d       = lock_q;
      owner_d      = owner_q;

      if (fire) begin
         mem_action_d = legal ? sel_act : 8'd0;
         mem_array_d  = req_array[int'(gid)*ARRAY_BITS +: ARRAY_BITS];
         mem_index_d  = req_index[int'(gid)*INDEX_BITS +: INDEX_BITS];
         mem_in_d     = req_in[int'(gid)*DATA_BITS +: DATA_BITS];
         tag1_d.vld   = 1'b1;
         tag1_d.id    = gid;
         tag1_d.rd    = returns_data;
         if (!lock_q)
            ptr_d = (gid == IW'(REQUESTERS-1)) ? '0 : gid + 1'b1;
         // While locked only the owner can fire, so gid is the owner here
         if (sel_act == ACT_LONG1) begin
            lock_d  = 1'b1;
            owner_d = gid;
         end else if (sel_act == ACT_LONG2 && lock_q) begin
            lock_d  = 1'b0;
         end
      end

      tag2_d       = tag1_q;
      resp_valid_d = '0;
      if (tag2_q.vld) resp_valid_d[tag2_q.id] = 1'b1;
      resp_data_d  = (tag2_q.vld && tag2_q.rd) ? mem_out : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q        <= '0;
         lock_q       <= 1'b0;
         owner_q      <= '0;
         tag1_q       <= '0;
         tag2_q       <= '0;
         mem_action_q <= '0;
         mem_array_q  <= '0;
         mem_index_q  <= '0;
         mem_in_q     <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         ptr_q        <= ptr_d;
         lock_q       <= lock_d;
         owner_q      <= owner_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
         mem_action_q <= mem_action_d;
         mem_array_q  <= mem_array_d;
         mem_index_q  <= mem_index_d;
         mem_in_q     <= mem_in_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign mem_action  = mem_action_q;
   assign mem_array   = mem_array_q;
   assign mem_index   = mem_index_q;
   assign mem_in      = mem_in_q;
   assign resp_valid  = resp_valid_q;
   assign resp_data   = resp_data_q;
   assign lock_active = lock_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a tiny behavioural Memory stand-in.
// Memory returns the written data, an address pattern on Read, else 0xC0<action>.
module tb_memory_arbiter;

   localparam int R = 4;

   logic         clock;
   logic         reset_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [31:0]  req_action;
   logic [63:0]  req_array;
   logic [11:0]  req_index;
   logic [63:0]  req_in;
   logic [3:0]   resp_valid;
   logic [15:0]  resp_data;
   logic [7:0]   mem_action;
   logic [15:0]  mem_array;
   logic [2:0]   mem_index;
   logic [15:0]  mem_in;
   logic [15:0]  mem_out;
   logic         lock_active;

   int n_checks;
   int n_errors;

   memory_arbiter #(
      .REQUESTERS(R), .ARRAY_BITS(16), .INDEX_BITS(3), .DATA_BITS(16)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_action(req_action), .req_array(req_array),
      .req_index(req_index), .req_in(req_in),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .mem_action(mem_action), .mem_array(mem_array),
      .mem_index(mem_index), .mem_in(mem_in),
      .mem_out(mem_out), .lock_active(lock_active)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      case (mem_action)
         8'd2:    mem_out <= mem_in;
         8'd3:    mem_out <= 16'h1000 + {8'h00, mem_array[3:0], 4'h0}
                             + {13'h0, mem_index};
         default: mem_out <= {8'hC0, mem_action};
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] a,
                          input logic [15:0] arr, input logic [2:0] ix,
                          input logic [15:0] d);
      req_valid[i]        = 1'b1;
      req_action[i*8 +: 8]  = a;
      req_array[i*16 +: 16] = arr;
      req_index[i*3 +: 3]   = ix;
      req_in[i*16 +: 16]    = d;
   endtask

   task automatic clr_all();
      req_valid  = '0;
      req_action = '0;
      req_array  = '0;
      req_index  = '0;
      req_in     = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rr_exp [4];
      rr_exp = '{16'h1001, 16'h1011, 16'h1021, 16'h1031};
      n_checks = 0;
      n_errors = 0;
      clock    = 1'b0;
      reset_n  = 1'b0;
      clr_all();
      req_valid = 4'hF;

      // reset state, ready held low while in reset
      repeat (2) @(negedge clock);
      chk("rst_ready", req_ready, 4'h0);
      chk("rst_mem_action", mem_action, 8'h0);
      chk("rst_resp_valid", resp_valid, 4'h0);
      chk("rst_resp_data", resp_data, 16'h0);
      chk("rst_lock", lock_active, 1'b0);

      // command in flight, then async reset mid-run
      clr_all();
      reset_n = 1'b1;
      set_req(0, 8'd2, 16'd1, 3'd2, 16'h0055);
      #1 chk("flight_ready", req_ready, 4'b0001);
      tick();
      clr_all();
      chk("flight_mem_action", mem_action, 8'd2);
      reset_n = 1'b0;
      #1;
      chk("arst_mem_action", mem_action, 8'h0);
      chk("arst_mem_array", mem_array, 16'h0);
      chk("arst_mem_in", mem_in, 16'h0);
      chk("arst_mem_index", mem_index, 3'h0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("arst_no_resp", resp_valid, 4'h0);
      end

      // simple write from client 0
      set_req(0, 8'd2, 16'd1, 3'd2, 16'h0055);
      #1 chk("wr_ready", req_ready, 4'b0001);
      tick();
      clr_all();
      chk("wr_mem_action", mem_action, 8'd2);
      chk("wr_mem_array", mem_array, 16'd1);
      chk("wr_mem_index", mem_index, 3'd2);
      chk("wr_mem_in", mem_in, 16'h0055);
      tick();
      chk("wr_resp_early", resp_valid, 4'h0);
      tick();
      chk("wr_resp_valid", resp_valid, 4'b0001);
      chk("wr_resp_data", resp_data, 16'h0055);
      tick();
      chk("wr_resp_pulse", resp_valid, 4'h0);

      // reset pulse brings the pointer back to 0
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
      #1;

      // round robin with all clients reading continuously
      for (int i = 0; i < R; i++) set_req(i, 8'd3, 16'(i), 3'd1, 16'h0);
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c < 5)
            chk("rr_ready", req_ready, 32'(4'b0001 << (c % 4)));
         if (c >= 3) begin
            chk("rr_resp_valid", resp_valid, 32'(4'b0001 << ((c - 3) % 4)));
            chk("rr_resp_data", resp_data, rr_exp[(c - 3) % 4]);
         end
         tick();
         if (c == 4) clr_all();
      end

      // move the pointer to 2 with one read from client 1
      set_req(1, 8'd3, 16'd0, 3'd0, 16'h0);
      #1 chk("ptr_ready", req_ready, 4'b0010);
      tick();
      clr_all();

      // lock held by client 2 across Long1/Long2
      set_req(0, 8'd3, 16'd0, 3'd0, 16'h0);
      set_req(1, 8'd3, 16'd1, 3'd0, 16'h0);
      set_req(3, 8'd3, 16'd3, 3'd1, 16'h0);
      set_req(2, 8'd12, 16'd1, 3'd0, 16'h0);
      #1 chk("lk_ready", req_ready, 4'b0100);
      tick();
      chk("lk_active", lock_active, 1'b1);
      chk("lk_mem_action", mem_action, 8'd12);
      req_valid[2] = 1'b0;
      #1 chk("lk_owner_idle", req_ready, 4'h0);
      tick();
      chk("lk_no_xfer", mem_action, 8'd0);
      chk("lk_held", lock_active, 1'b1);
      chk("lk_rd1_valid", resp_valid, 4'b0010);
      chk("lk_rd1_data", resp_data, 16'h1000);
      set_req(2, 8'd13, 16'd2, 3'd0, 16'h0003);
      #1 chk("lk2_ready", req_ready, 4'b0100);
      tick();
      chk("lk2_clear", lock_active, 1'b0);
      chk("lk2_mem_action", mem_action, 8'd13);
      chk("lk2_mem_array", mem_array, 16'd2);
      chk("lk2_mem_in", mem_in, 16'h0003);
      chk("lk1_resp_valid", resp_valid, 4'b0100);
      chk("lk1_resp_data", resp_data, 16'h0);
      req_valid[2] = 1'b0;
      #1 chk("unlk_ready", req_ready, 4'b1000);
      tick();
      clr_all();
      chk("unlk_mem_action", mem_action, 8'd3);
      chk("unlk_mem_array", mem_array, 16'd3);
      repeat (3) tick();

      // non-data actions back to back, then Size
      set_req(0, 8'd14, 16'd1, 3'd0, 16'h0007);
      #1 chk("nd_ready", req_ready, 4'b0001);
      tick();
      chk("nd_mem_action", mem_action, 8'd14);
      set_req(0, 8'd5, 16'd1, 3'd0, 16'h0);
      tick();
      set_req(0, 8'd4, 16'd1, 3'd0, 16'h0);
      tick();
      clr_all();
      chk("nd_push_valid", resp_valid, 4'b0001);
      chk("nd_push_data", resp_data, 16'h0);
      tick();
      chk("nd_inc_valid", resp_valid, 4'b0001);
      chk("nd_inc_data", resp_data, 16'h0);
      tick();
      chk("nd_size_valid", resp_valid, 4'b0001);
      chk("nd_size_data", resp_data, 16'hC004);
      tick();

      // illegal action code
      set_req(1, 8'd20, 16'd1, 3'd1, 16'h0009);
      #1 chk("ill_ready", req_ready, 4'b0010);
      tick();
      clr_all();
      chk("ill_mem_action", mem_action, 8'd0);
      tick();
      chk("ill_resp_early", resp_valid, 4'h0);
      tick();
      chk("ill_resp_valid", resp_valid, 4'b0010);
      chk("ill_resp_data", resp_data, 16'h0);

      // backpressure on client 0 while client 1 holds the lock
      set_req(1, 8'd12, 16'd0, 3'd0, 16'h0);
      #1 chk("bp_lk_ready", req_ready, 4'b0010);
      tick();
      clr_all();
      chk("bp_lock", lock_active, 1'b1);
      set_req(0, 8'd3, 16'd1, 3'd1, 16'h0);
      #1 chk("bp_stall1", req_ready, 4'h0);
      tick();
      chk("bp_no_xfer1", mem_action, 8'd0);
      set_req(0, 8'd2, 16'd3, 3'd5, 16'h0077);
      #1 chk("bp_stall2", req_ready, 4'h0);
      tick();
      chk("bp_no_xfer2", mem_action, 8'd0);
      set_req(1, 8'd13, 16'd0, 3'd0, 16'h0);
      #1 chk("bp_owner_ready", req_ready, 4'b0010);
      tick();
      req_valid[1] = 1'b0;
      #1;
      chk("bp_unlock", lock_active, 1'b0);
      chk("bp_grant0", req_ready, 4'b0001);
      tick();
      clr_all();
      chk("bp_mem_action", mem_action, 8'd2);
      chk("bp_mem_array", mem_array, 16'd3);
      chk("bp_mem_index", mem_index, 3'd5);
      chk("bp_mem_in", mem_in, 16'h0077);
      tick();
      tick();
      chk("bp_resp_valid", resp_valid, 4'b0001);
      chk("bp_resp_data", resp_data, 16'h0077);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
